// File: rtl/sde_ps_pack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sde_ps_pack                                                   |
// | Purpose  : Packs DW-granular PCIS write beats into ACC_WIDTH words,      |
// |            queues them in an output FIFO, optional partial flush on      |
// |            wlast, sticky strobe/alignment/ordering error flags.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sde_ps_pack #(
  parameter int                         PCIS_DATA_WIDTH = 512,
  parameter int                         PCIS_ADDR_WIDTH = 64,
  parameter int                         ACC_WIDTH       = 256,
  parameter int                         OUT_FIFO_DEPTH  = 4,
  parameter bit                         FLUSH_ON_LAST   = 1'b1,
  parameter logic [PCIS_ADDR_WIDTH-1:0] START_ADDR      = '0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  pcis_req_wr,
  input  logic [PCIS_ADDR_WIDTH-1:0]            pcis_req_addr,
  input  logic [PCIS_DATA_WIDTH-1:0]            pcis_wdata,
  input  logic [PCIS_DATA_WIDTH/8-1:0]          pcis_wstrb,
  input  logic                                  pcis_wlast,
  input  logic                                  pcis_wvalid,
  output logic                                  pcis_wready,
  output logic                                  acc_wr_req,
  output logic [ACC_WIDTH-1:0]                  acc_wdata,
  output logic [$clog2(ACC_WIDTH/32):0]         acc_wr_num_dw,
  output logic                                  acc_wr_last,
  input  logic                                  acc_ack,
  output logic [$clog2(OUT_FIFO_DEPTH):0]       out_fifo_cnt,
  output logic                                  ooo_error,
  output logic                                  unalin_error,
  output logic                                  strb_error
);

  localparam int C_PCIS_DW = PCIS_DATA_WIDTH / 32;
  localparam int C_ACC_DW  = ACC_WIDTH / 32;
  localparam int C_NUM_W   = $clog2(C_ACC_DW) + 1;
  localparam int C_REM_W   = $clog2(C_PCIS_DW) + 1;
  localparam int C_PTR_W   = $clog2(OUT_FIFO_DEPTH);
  localparam int C_CNT_W   = C_PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAIN = 2'd1, S_FLUSH = 2'd2} state_t;

  state_t                       r_state, w_state_next;
  logic [PCIS_DATA_WIDTH-1:0]   r_hold_data;
  logic [C_REM_W-1:0]           r_rem;
  logic                         r_hold_last;
  logic [ACC_WIDTH-1:0]         r_pack;
  logic [C_NUM_W-1:0]           r_acc_cnt;
  logic [ACC_WIDTH-1:0]         r_fifo_data [OUT_FIFO_DEPTH];
  logic [C_NUM_W-1:0]           r_fifo_num  [OUT_FIFO_DEPTH];
  logic                         r_fifo_last [OUT_FIFO_DEPTH];
  logic [C_PTR_W-1:0]           r_wr_ptr, r_rd_ptr;
  logic [C_CNT_W-1:0]           r_cnt;
  logic [PCIS_ADDR_WIDTH-1:0]   r_prev_addr;
  logic                         r_ooo, r_unalin, r_strb;

  int                           w_lo, w_hi, w_beat_dw, w_acc_i, w_rem_i, w_move, w_new_cnt, w_rem_next;
  logic                         w_any, w_strb_bad, w_accept, w_pop, w_can_push, w_full_word;
  logic [ACC_WIDTH-1:0]         w_ins, w_merged, w_push_data;
  logic [C_NUM_W-1:0]           w_push_num;
  logic                         w_push_en, w_push_last, w_drain_go, w_flush_done;

  assign pcis_wready = pcis_req_wr & (r_state == S_IDLE);
  assign w_accept    = pcis_wvalid & pcis_wready;
  assign acc_wr_req  = (r_cnt != '0);
  assign w_pop       = acc_wr_req & acc_ack;
  // A pop in the same cycle frees the slot a full FIFO would otherwise block.
  assign w_can_push  = (r_cnt != C_CNT_W'(OUT_FIFO_DEPTH)) | w_pop;

  // Beat decode: DW span [lo,hi]; any incomplete DW inside the span is a strobe error.
  always_comb begin
    w_lo       = 0;
    w_hi       = 0;
    w_any      = 1'b0;
    w_strb_bad = 1'b0;
    for (int i = C_PCIS_DW - 1; i >= 0; i--) begin
      if (|pcis_wstrb[i*4 +: 4]) w_lo = i;
    end
    for (int i = 0; i < C_PCIS_DW; i++) begin
      if (|pcis_wstrb[i*4 +: 4]) begin
        w_hi  = i;
        w_any = 1'b1;
      end
    end
    for (int i = 0; i < C_PCIS_DW; i++) begin
      if (w_any && i >= w_lo && i <= w_hi && !(&pcis_wstrb[i*4 +: 4])) w_strb_bad = 1'b1;
    end
    w_beat_dw = w_any ? (w_hi - w_lo + 1) : 0;
  end

  // Pack merge: place min(remaining, room) held DWs above the current pack contents.
  always_comb begin
    w_acc_i     = int'(r_acc_cnt);
    w_rem_i     = int'(r_rem);
    w_move      = (w_rem_i < (C_ACC_DW - w_acc_i)) ? w_rem_i : (C_ACC_DW - w_acc_i);
    w_new_cnt   = w_acc_i + w_move;
    w_rem_next  = w_rem_i - w_move;
    w_full_word = (w_new_cnt == C_ACC_DW);
    w_ins       = r_hold_data[ACC_WIDTH-1:0] << (w_acc_i * 32);
    w_merged    = r_pack;
    for (int j = 0; j < C_ACC_DW; j++) begin
      if (j >= w_acc_i && j < w_new_cnt) w_merged[j*32 +: 32] = w_ins[j*32 +: 32];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next state and push control.
  always_comb begin
    w_state_next = r_state;
    w_push_en    = 1'b0;
    w_push_data  = r_pack;
    w_push_num   = r_acc_cnt;
    w_push_last  = 1'b0;
    w_drain_go   = 1'b0;
    w_flush_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        // Stall only when this cycle would complete a word and the FIFO cannot take it.
        if (!(w_full_word && !w_can_push)) begin
          w_drain_go = 1'b1;
          if (w_full_word) begin
            w_push_en   = 1'b1;
            w_push_data = w_merged;
            w_push_num  = C_NUM_W'(C_ACC_DW);
            w_push_last = FLUSH_ON_LAST && r_hold_last && (w_rem_next == 0);
          end
          if (w_rem_next == 0) begin
            if (FLUSH_ON_LAST && r_hold_last && !w_full_word && w_new_cnt > 0)
              w_state_next = S_FLUSH;
            else
              w_state_next = S_IDLE;
          end
        end
      end
      S_FLUSH: begin
        w_push_en   = w_can_push;
        w_push_last = 1'b1;
        if (w_can_push) begin
          w_flush_done = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Holding and pack registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold_data <= '0;
      r_rem       <= '0;
      r_hold_last <= 1'b0;
      r_pack      <= '0;
      r_acc_cnt   <= '0;
    end else if (w_accept) begin
      r_hold_data <= pcis_wdata >> (w_lo * 32);
      r_rem       <= C_REM_W'(w_beat_dw);
      r_hold_last <= pcis_wlast;
    end else if (w_drain_go) begin
      r_hold_data <= r_hold_data >> (w_move * 32);
      r_rem       <= C_REM_W'(w_rem_next);
      if (w_full_word) begin
        r_pack    <= '0;
        r_acc_cnt <= '0;
      end else begin
        r_pack    <= w_merged;
        r_acc_cnt <= C_NUM_W'(w_new_cnt);
      end
    end else if (w_flush_done) begin
      r_pack    <= '0;
      r_acc_cnt <= '0;
    end
  end

  // FIFO storage; contents are don't-care while the entry is not counted.
  always_ff @(posedge clk) begin
    if (w_push_en) begin
      r_fifo_data[r_wr_ptr] <= w_push_data;
      r_fifo_num[r_wr_ptr]  <= w_push_num;
      r_fifo_last[r_wr_ptr] <= w_push_last;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_en, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Head-of-FIFO outputs are forced to zero while the FIFO is empty.
  assign acc_wdata     = acc_wr_req ? r_fifo_data[r_rd_ptr] : '0;
  assign acc_wr_num_dw = acc_wr_req ? r_fifo_num[r_rd_ptr]  : '0;
  assign acc_wr_last   = acc_wr_req ? r_fifo_last[r_rd_ptr] : 1'b0;
  assign out_fifo_cnt  = r_cnt;

  // Sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev_addr <= '0;
      r_ooo       <= 1'b0;
      r_unalin    <= 1'b0;
      r_strb      <= 1'b0;
    end else begin
      if (pcis_req_wr) r_prev_addr <= pcis_req_addr;
      if (pcis_req_wr && pcis_req_addr[1:0] != 2'b00) r_unalin <= 1'b1;
      if (pcis_req_wr && pcis_req_addr < r_prev_addr && pcis_req_addr != START_ADDR) r_ooo <= 1'b1;
      if (w_accept && w_strb_bad) r_strb <= 1'b1;
    end
  end

  assign ooo_error    = r_ooo;
  assign unalin_error = r_unalin;
  assign strb_error   = r_strb;

endmodule
`default_nettype wire

// File: doc/sde_ps_pack.md
# sde_ps_pack

Parametrised successor to the SDE PCIS write accumulator. It sits between the PS FSM / PCIS write-data channel and the descriptor/data sink. It packs DW-granular PCIS write beats of any DW offset and length into ACC_WIDTH words and buffers them in an output FIFO. It also optionally flushes a partial word, tagged with its DW count, on `pcis_wlast`. Strobe-contiguity, alignment and ordering errors are reported as sticky flags.

## Interface
- `PCIS_DATA_WIDTH`, 512: PCIS data bus width; multiple of 32.
- `PCIS_ADDR_WIDTH`, 64: request address width.
- `ACC_WIDTH`, 256: output word width; multiple of 32 and ≤ `PCIS_DATA_WIDTH`. `ACC_DW = ACC_WIDTH/32`.
- `OUT_FIFO_DEPTH`, 4: output FIFO entries; power of 2, ≥ 2.
- `FLUSH_ON_LAST`, 1: 1 emits a residual partial word at `wlast`; 0 carries the residual into the next burst.
- `START_ADDR`, 0: address exempt from the out-of-order check.
- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  synchronous, active-low reset.
- `pcis_req_wr`  in  1  PS FSM grants write data acceptance.
- `pcis_req_addr`  in  `PCIS_ADDR_WIDTH`  burst address, sampled while `pcis_req_wr`.
- `pcis_wdata`  in  `PCIS_DATA_WIDTH`  write data.
- `pcis_wstrb`  in  `PCIS_DATA_WIDTH/8`  byte strobes.
- `pcis_wlast`  in  1  last beat of burst.
- `pcis_wvalid`  in  1  beat valid.
- `pcis_wready`  out  1  beat accepted when `pcis_wvalid & pcis_wready`.
- `acc_wr_req`  out  1  output word valid (FIFO not empty).
- `acc_wdata`  out  `ACC_WIDTH`  output word; DW0 in bits [31:0].
- `acc_wr_num_dw`  out  `$clog2(ACC_DW)+1`  valid DWs in `acc_wdata`, range 1..`ACC_DW`.
- `acc_wr_last`  out  1  word ends a burst (only when `FLUSH_ON_LAST`=1).
- `acc_ack`  in  1  sink pops the word.
- `out_fifo_cnt`  out  `$clog2(OUT_FIFO_DEPTH)+1`  FIFO occupancy.
- `ooo_error`, `unalin_error`, `strb_error`  out  1 each  sticky error flags.

## Operation
- **Beat decode.** A DW is set if any of its 4 strobe bits is set.
  - `lo`/`hi` = lowest/highest set DW. The beat contributes `hi-lo+1` DWs, starting at DW `lo`.
  - A gap, or a set DW whose strobes are incomplete, sets `strb_error`; the data is still taken.
  - An all-zero strobe contributes 0 DWs but still honours `wlast`.
- **Holding register.** Stores data shifted right by `lo` DWs, the remaining DW count and a last flag.
  - `pcis_wready = pcis_req_wr & (state==IDLE)`.
- **FSM.**
  - IDLE → DRAIN on accept.
  - DRAIN moves `min(remaining, ACC_DW - acc_cnt)` DWs per cycle into the pack register. It does not move data on a cycle where a push is required and the FIFO is full.
  - When `acc_cnt` reaches `ACC_DW`, push a full word and clear `acc_cnt` in the same cycle.
  - When `remaining` reaches 0: if last, `FLUSH_ON_LAST`=1 and `acc_cnt>0`, go to FLUSH; else go to IDLE.
  - FLUSH pushes `{zeros, pack}` with `num_dw=acc_cnt`, `last=1`, then goes to IDLE once the push is accepted.
  - A full word that exactly completes a last beat is pushed with `last=1` and needs no FLUSH.
- **Output FIFO.**
  - Pop on `acc_wr_req & acc_ack`.
  - `acc_wdata`, `acc_wr_num_dw` and `acc_wr_last` stay stable while `acc_wr_req & ~acc_ack`.
  - Simultaneous push and pop on a full FIFO is allowed: the pop frees the slot.
- **Errors** are sticky until reset:
  - `unalin_error`: `pcis_req_wr & pcis_req_addr[1:0]!=0`.
  - `ooo_error`: `pcis_req_wr & addr < previous addr & addr != START_ADDR`.
- **Reset values.** All outputs 0, except `pcis_wready`, which is 0 whenever `pcis_req_wr` is 0. FSM goes to IDLE; FIFO, pack register and counters are cleared.
- **Reset mid-operation** discards held, packed and queued data with no partial output.

## Timing
- Beat accepted at cycle N; its first push happens at end of N+1 at the earliest; `acc_wr_req` rises at N+2.
- Sustained rate: one output word per cycle while draining and the FIFO is not full.
- A beat of D DWs occupies DRAIN for `ceil((acc_cnt+D)/ACC_DW)` cycles, minimum 1.
- The next beat is accepted the cycle after DRAIN/FLUSH returns to IDLE.
- FIFO full: DRAIN/FLUSH hold with no data loss; `pcis_wready` stays 0.
- Error flags assert 1 cycle after the offending request.

## Test plan
- **Full-width packing** (`ACC_WIDTH`=256): one 16-DW beat, `wlast`, `acc_ack` tied 1 → two words, `num_dw`=8; `last` 0 then 1; `acc_wr_req` first at N+2.
- **Offset beat with flush:** DW offset 3 (strobes DW3..DW7, 5 DWs), `wlast`, `FLUSH_ON_LAST`=1 → one word, `num_dw`=5, DW0 = input DW3, upper DWs 0, `last`=1.
- **Carry mode:** `FLUSH_ON_LAST`=0, bursts of 4 DW then 4 DW (each with `wlast`) → single word, `num_dw`=8, contains DWs in order.
- **Backpressure:** `acc_ack`=0, `OUT_FIFO_DEPTH`=4, feed 5 × 8-DW beats → `out_fifo_cnt`=4, `pcis_wready`=0. Release `acc_ack` → 5 words in order, none lost or duplicated.
- **Error flags:** strobe gap (DW0, DW2 set) → `strb_error`=1. Address 0x102 → `unalin_error`=1. Address 0x100 then 0x40 → `ooo_error`=1. Address 0x100 then `START_ADDR` → no `ooo_error`.
- **Reset mid-operation:** assert `rst_n`=0 during DRAIN with FIFO at 2 → next cycle all outputs 0, `out_fifo_cnt`=0; the following burst packs from DW0.
